// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - encodings, instruction classes and Tuse/Tnew constants
package cpu_defs_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;
    localparam logic [5:0] FN_ERET    = 6'h18;

    localparam logic [4:0] RS_MF      = 5'h00;
    localparam logic [4:0] RS_MT      = 5'h04;
    localparam logic [4:0] RS_CO      = 5'h10;

    localparam int CLASS_W = 4;

    typedef enum logic [CLASS_W-1:0] {
        CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_LUI,
        CLS_MDU_START, CLS_MDU_MF, CLS_MDU_MT, CLS_LOAD,
        CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JR,
        CLS_SYSCALL, CLS_ERET, CLS_MFC0, CLS_MTC0
    } instr_class_e;

    // TUSE_NONE marks a register field the instruction does not read
    localparam int         TUSE_W    = 2;
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0    = 2'd0;
    localparam logic [1:0] TNEW_1    = 2'd1;
    localparam logic [1:0] TNEW_2    = 2'd2;

endpackage

// File: rtl/instr_decode_pipe_if.sv
// rtl/instr_decode_pipe_if.sv - D-stage inputs and E-stage outputs of the decode pipe
interface instr_decode_pipe_if #(
    parameter int TNEW_W = 2
);
    logic [31:0]                instr;
    logic                       d_valid;
    logic                       mdu_busy;
    logic                       flush;
    logic                       stall_out;
    logic                       e_valid;
    cpu_defs_pkg::instr_class_e e_class;
    logic [4:0]                 e_rs;
    logic [4:0]                 e_rt;
    logic [4:0]                 e_dst;
    logic [TNEW_W-1:0]          e_tnew;
    logic                       e_ri;
    logic                       e_sys;

    modport master (
        output instr, d_valid, mdu_busy, flush,
        input  stall_out, e_valid, e_class, e_rs, e_rt, e_dst, e_tnew, e_ri, e_sys
    );

    modport slave (
        input  instr, d_valid, mdu_busy, flush,
        output stall_out, e_valid, e_class, e_rs, e_rt, e_dst, e_tnew, e_ri, e_sys
    );
endinterface

// File: rtl/instr_class_decode.sv
// rtl/instr_class_decode.sv - combinational class, register, Tuse and Tnew decode
module instr_class_decode
    import cpu_defs_pkg::*;
#(
    parameter int TNEW_W = 2
) (
    input  logic [31:0]       instr,
    output instr_class_e      cls,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        dst,
    output logic [TUSE_W-1:0] tuse_rs,
    output logic [TUSE_W-1:0] tuse_rt,
    output logic [TNEW_W-1:0] tnew,
    output logic              ri,
    output logic              sys
);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rd;
    logic [1:0] tnew_c;

    assign op = instr[31:26];
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign rd = instr[15:11];
    assign fn = instr[5:0];

    always_comb begin
        cls     = CLS_NOP;
        dst     = 5'd0;
        tuse_rs = TUSE_NONE;
        tuse_rt = TUSE_NONE;
        tnew_c  = TNEW_0;
        ri      = 1'b0;
        sys     = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: begin
                        cls = CLS_ALU_R; dst = rd; tuse_rs = TUSE_1; tuse_rt = TUSE_1; tnew_c = TNEW_1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        cls = CLS_MDU_START; tuse_rs = TUSE_1; tuse_rt = TUSE_1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        cls = CLS_MDU_MF; dst = rd; tnew_c = TNEW_1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        cls = CLS_MDU_MT; tuse_rs = TUSE_1;
                    end
                    FN_JR: begin
                        cls = CLS_JR; tuse_rs = TUSE_0;
                    end
                    FN_SYSCALL: begin
                        cls = CLS_SYSCALL; sys = 1'b1;
                    end
                    // funct 0 is only legal as the canonical all-zero NOP
                    default: ri = (instr != 32'd0);
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                cls = CLS_ALU_I; dst = rt; tuse_rs = TUSE_1; tnew_c = TNEW_1;
            end
            OP_LUI: begin
                cls = CLS_LUI; dst = rt; tnew_c = TNEW_1;
            end
            OP_LB, OP_LH, OP_LW: begin
                cls = CLS_LOAD; dst = rt; tuse_rs = TUSE_1; tnew_c = TNEW_2;
            end
            OP_SB, OP_SH, OP_SW: begin
                cls = CLS_STORE; tuse_rs = TUSE_1; tuse_rt = TUSE_2;
            end
            OP_BEQ, OP_BNE: begin
                cls = CLS_BRANCH; tuse_rs = TUSE_0; tuse_rt = TUSE_0;
            end
            OP_JAL: begin
                cls = CLS_JAL; dst = 5'd31;
            end
            OP_COP0: begin
                case (rs)
                    RS_MF: begin cls = CLS_MFC0; dst = rt; tnew_c = TNEW_2; end
                    RS_MT: begin cls = CLS_MTC0; tuse_rt = TUSE_2; end
                    RS_CO: begin
                        if (fn == FN_ERET) cls = CLS_ERET;
                        else ri = 1'b1;
                    end
                    default: ri = 1'b1;
                endcase
            end
            default: ri = 1'b1;
        endcase
    end

    assign tnew = TNEW_W'(tnew_c);

endmodule

// File: rtl/instr_decode_pipe.sv
// rtl/instr_decode_pipe.sv - hazard scoreboard, stall generation and E-stage register
module instr_decode_pipe
    import cpu_defs_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int TNEW_W    = 2,
    parameter int MDU_STALL = 1
) (
    input  logic               clk,
    input  logic               reset,
    instr_decode_pipe_if.slave bus
);
    instr_class_e      d_class;
    logic [4:0]        d_rs, d_rt, d_dst;
    logic [TUSE_W-1:0] d_tuse_rs, d_tuse_rt;
    logic [TNEW_W-1:0] d_tnew;
    logic              d_ri, d_sys;

    instr_class_decode #(.TNEW_W(TNEW_W)) u_dec (
        .instr   (bus.instr),
        .cls     (d_class),
        .rs      (d_rs),
        .rt      (d_rt),
        .dst     (d_dst),
        .tuse_rs (d_tuse_rs),
        .tuse_rt (d_tuse_rt),
        .tnew    (d_tnew),
        .ri      (d_ri),
        .sys     (d_sys)
    );

    logic [STAGES-1:0] sb_valid;
    logic [4:0]        sb_dst  [STAGES];
    logic [TNEW_W-1:0] sb_tnew [STAGES];

    instr_class_e e_class_q;
    logic [4:0]   e_rs_q, e_rt_q;
    logic         e_ri_q, e_sys_q;

    logic raw_hazard, mdu_hazard, d_is_mdu, stall, issue;

    always_comb begin
        raw_hazard = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (sb_valid[i] && sb_dst[i] != 5'd0) begin
                if (d_tuse_rs != TUSE_NONE && d_rs == sb_dst[i] &&
                    int'(sb_tnew[i]) > int'(d_tuse_rs))
                    raw_hazard = 1'b1;
                if (d_tuse_rt != TUSE_NONE && d_rt == sb_dst[i] &&
                    int'(sb_tnew[i]) > int'(d_tuse_rt))
                    raw_hazard = 1'b1;
            end
        end
    end

    // Entry 0 and the E register load together, so e_class_q is entry 0's class
    assign d_is_mdu   = (d_class == CLS_MDU_START) || (d_class == CLS_MDU_MF) ||
                        (d_class == CLS_MDU_MT);
    assign mdu_hazard = (MDU_STALL != 0) && d_is_mdu &&
                        (bus.mdu_busy || (sb_valid[0] && e_class_q == CLS_MDU_START));
    assign stall      = !reset && !bus.flush && bus.d_valid && (raw_hazard || mdu_hazard);
    assign issue      = bus.d_valid && !stall;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            sb_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sb_dst[i]  <= 5'd0;
                sb_tnew[i] <= '0;
            end
            e_class_q <= CLS_NOP;
            e_rs_q    <= 5'd0;
            e_rt_q    <= 5'd0;
            e_ri_q    <= 1'b0;
            e_sys_q   <= 1'b0;
        end else begin
            for (int i = 1; i < STAGES; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_dst[i]   <= sb_dst[i-1];
                sb_tnew[i]  <= (sb_tnew[i-1] != '0) ? sb_tnew[i-1] - TNEW_W'(1) : '0;
            end
            sb_valid[0] <= issue;
            sb_dst[0]   <= issue ? d_dst : 5'd0;
            sb_tnew[0]  <= issue ? d_tnew : '0;
            e_class_q   <= issue ? d_class : CLS_NOP;
            e_rs_q      <= issue ? d_rs : 5'd0;
            e_rt_q      <= issue ? d_rt : 5'd0;
            e_ri_q      <= issue && d_ri;
            e_sys_q     <= issue && d_sys;
        end
    end

    assign bus.stall_out = stall;
    assign bus.e_valid   = sb_valid[0];
    assign bus.e_class   = e_class_q;
    assign bus.e_rs      = e_rs_q;
    assign bus.e_rt      = e_rt_q;
    assign bus.e_dst     = sb_dst[0];
    assign bus.e_tnew    = sb_tnew[0];
    assign bus.e_ri      = e_ri_q;
    assign bus.e_sys     = e_sys_q;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb/tb_instr_decode_pipe.sv - table-driven bench for instr_decode_pipe (STAGES 3 and 4)
module tb_instr_decode_pipe;
    import cpu_defs_pkg::*;

    logic clk = 1'b0;
    logic reset;

    instr_decode_pipe_if #(.TNEW_W(2)) bus3 ();
    instr_decode_pipe_if #(.TNEW_W(2)) bus4 ();

    instr_decode_pipe #(.STAGES(3), .TNEW_W(2), .MDU_STALL(1)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );
    instr_decode_pipe #(.STAGES(4), .TNEW_W(2), .MDU_STALL(1)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    assign bus4.instr    = bus3.instr;
    assign bus4.d_valid  = bus3.d_valid;
    assign bus4.mdu_busy = bus3.mdu_busy;
    assign bus4.flush    = bus3.flush;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  instr;
        logic         dv, busy, fl;
        logic         stall, ev;
        instr_class_e cls;
        logic [4:0]   dst;
        logic [1:0]   tnew;
        logic         ri, sys;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic dv, input logic busy,
                                input logic fl, input logic st, input logic ev,
                                input instr_class_e cls, input logic [4:0] dst,
                                input logic [1:0] tn, input logic ri, input logic sys);
        vec_t v;
        v.instr = ins; v.dv = dv; v.busy = busy; v.fl = fl;
        v.stall = st; v.ev = ev; v.cls = cls; v.dst = dst; v.tnew = tn; v.ri = ri; v.sys = sys;
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " stall3"}, 32'(bus3.stall_out), 32'd0);
        check({tag, " stall4"}, 32'(bus4.stall_out), 32'd0);
        check({tag, " e_valid3"}, 32'(bus3.e_valid), 32'd0);
        check({tag, " e_valid4"}, 32'(bus4.e_valid), 32'd0);
        check({tag, " e_class3"}, 32'(bus3.e_class), 32'(CLS_NOP));
        check({tag, " e_class4"}, 32'(bus4.e_class), 32'(CLS_NOP));
        check({tag, " e_dst3"}, 32'(bus3.e_dst), 32'd0);
        check({tag, " e_tnew3"}, 32'(bus3.e_tnew), 32'd0);
        check({tag, " e_ri3"}, 32'(bus3.e_ri), 32'd0);
        check({tag, " e_sys3"}, 32'(bus3.e_sys), 32'd0);
    endtask

    logic [31:0] lw8, add989, beq80, add812, ori8, sw89, bad, sysc, jal0, nop, add188, mult12, mflo3;
    logic [31:0] lw0, add900;

    initial begin
        lw8    = i_op(6'h23, 5'd0, 5'd8, 16'd0);
        add989 = r_op(6'h20, 5'd8, 5'd8, 5'd9);
        beq80  = i_op(6'h04, 5'd8, 5'd0, 16'd0);
        add812 = r_op(6'h20, 5'd1, 5'd2, 5'd8);
        ori8   = i_op(6'h0D, 5'd0, 5'd8, 16'd5);
        sw89   = i_op(6'h2B, 5'd9, 5'd8, 16'd0);
        bad    = 32'hFC00_0000;
        sysc   = 32'h0000_000C;
        jal0   = 32'h0C00_0000;
        nop    = 32'h0000_0000;
        add188 = r_op(6'h20, 5'd8, 5'd8, 5'd1);
        mult12 = r_op(6'h18, 5'd1, 5'd2, 5'd0);
        mflo3  = r_op(6'h12, 5'd0, 5'd0, 5'd3);
        lw0    = i_op(6'h23, 5'd0, 5'd0, 16'd0);
        add900 = r_op(6'h20, 5'd0, 5'd0, 5'd9);

        //             instr   dv busy fl  st ev  class          dst  tn ri sys
        vecs[0]  = mk(lw8,    1, 0, 0,  0, 0, CLS_NOP,       0,  0, 0, 0);
        vecs[1]  = mk(add989, 1, 0, 0,  1, 1, CLS_LOAD,      8,  2, 0, 0);
        vecs[2]  = mk(add989, 1, 0, 0,  0, 0, CLS_NOP,       0,  0, 0, 0);
        vecs[3]  = mk(lw8,    1, 0, 0,  0, 1, CLS_ALU_R,     9,  1, 0, 0);
        vecs[4]  = mk(beq80,  1, 0, 0,  1, 1, CLS_LOAD,      8,  2, 0, 0);
        vecs[5]  = mk(beq80,  1, 0, 0,  1, 0, CLS_NOP,       0,  0, 0, 0);
        vecs[6]  = mk(beq80,  1, 0, 0,  0, 0, CLS_NOP,       0,  0, 0, 0);
        vecs[7]  = mk(add812, 1, 0, 0,  0, 1, CLS_BRANCH,    0,  0, 0, 0);
        vecs[8]  = mk(beq80,  1, 0, 0,  1, 1, CLS_ALU_R,     8,  1, 0, 0);
        vecs[9]  = mk(beq80,  1, 0, 0,  0, 0, CLS_NOP,       0,  0, 0, 0);
        vecs[10] = mk(ori8,   1, 0, 0,  0, 1, CLS_BRANCH,    0,  0, 0, 0);
        vecs[11] = mk(sw89,   1, 0, 0,  0, 1, CLS_ALU_I,     8,  1, 0, 0);
        vecs[12] = mk(bad,    1, 0, 0,  0, 1, CLS_STORE,     0,  0, 0, 0);
        vecs[13] = mk(sysc,   1, 0, 0,  0, 1, CLS_NOP,       0,  0, 1, 0);
        vecs[14] = mk(jal0,   1, 0, 0,  0, 1, CLS_SYSCALL,   0,  0, 0, 1);
        vecs[15] = mk(nop,    1, 0, 0,  0, 1, CLS_JAL,       31, 0, 0, 0);
        vecs[16] = mk(lw8,    0, 0, 0,  0, 1, CLS_NOP,       0,  0, 0, 0);
        vecs[17] = mk(add188, 1, 0, 0,  0, 0, CLS_NOP,       0,  0, 0, 0);
        vecs[18] = mk(mult12, 1, 0, 0,  0, 1, CLS_ALU_R,     1,  1, 0, 0);
        vecs[19] = mk(mflo3,  1, 1, 0,  1, 1, CLS_MDU_START, 0,  0, 0, 0);
        for (int i = 20; i < 24; i++)
            vecs[i] = mk(mflo3, 1, 1, 0, 1, 0, CLS_NOP, 0, 0, 0, 0);
        vecs[24] = mk(mflo3,  1, 0, 0,  0, 0, CLS_NOP,       0,  0, 0, 0);
        vecs[25] = mk(nop,    1, 0, 0,  0, 1, CLS_MDU_MF,    3,  1, 0, 0);
        vecs[26] = mk(lw8,    1, 0, 0,  0, 1, CLS_NOP,       0,  0, 0, 0);
        vecs[27] = mk(add989, 1, 0, 1,  0, 1, CLS_LOAD,      8,  2, 0, 0);
        vecs[28] = mk(beq80,  1, 0, 0,  0, 0, CLS_NOP,       0,  0, 0, 0);
        vecs[29] = mk(nop,    1, 0, 0,  0, 1, CLS_BRANCH,    0,  0, 0, 0);

        reset = 1'b1;
        bus3.instr = 32'd0; bus3.d_valid = 1'b0; bus3.mdu_busy = 1'b0; bus3.flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus3.instr    = vecs[i].instr;
            bus3.d_valid  = vecs[i].dv;
            bus3.mdu_busy = vecs[i].busy;
            bus3.flush    = vecs[i].fl;
            #1;
            check($sformatf("row%0d stall3", i), 32'(bus3.stall_out), 32'(vecs[i].stall));
            check($sformatf("row%0d stall4", i), 32'(bus4.stall_out), 32'(vecs[i].stall));
            check($sformatf("row%0d e_valid", i), 32'(bus3.e_valid), 32'(vecs[i].ev));
            check($sformatf("row%0d e_class", i), 32'(bus3.e_class), 32'(vecs[i].cls));
            check($sformatf("row%0d e_dst", i), 32'(bus3.e_dst), 32'(vecs[i].dst));
            check($sformatf("row%0d e_tnew", i), 32'(bus3.e_tnew), 32'(vecs[i].tnew));
            check($sformatf("row%0d e_ri", i), 32'(bus3.e_ri), 32'(vecs[i].ri));
            check($sformatf("row%0d e_sys", i), 32'(bus3.e_sys), 32'(vecs[i].sys));
        end

        // $0 written by a load must never stall its consumer
        @(negedge clk);
        bus3.instr = lw0; bus3.d_valid = 1'b1; bus3.mdu_busy = 1'b0; bus3.flush = 1'b0;
        #1;
        check("r0 lw stall4", 32'(bus4.stall_out), 32'd0);
        @(negedge clk);
        bus3.instr = add900;
        #1;
        check("r0 use stall4", 32'(bus4.stall_out), 32'd0);
        check("r0 use stall3", 32'(bus3.stall_out), 32'd0);
        check("r0 e_valid4", 32'(bus4.e_valid), 32'd1);
        check("r0 e_class4", 32'(bus4.e_class), 32'(CLS_LOAD));
        check("r0 e_dst4", 32'(bus4.e_dst), 32'd0);

        // reset arriving in the middle of a load-use stall
        @(negedge clk);
        bus3.instr = lw8;
        #1;
        check("rst lw stall3", 32'(bus3.stall_out), 32'd0);
        @(negedge clk);
        bus3.instr = add989;
        #1;
        check("rst pre stall3", 32'(bus3.stall_out), 32'd1);
        check("rst pre stall4", 32'(bus4.stall_out), 32'd1);
        reset = 1'b1;
        #1;
        check("rst during stall3", 32'(bus3.stall_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state("post reset");
        @(negedge clk);
        #1;
        check("post reset issue e_valid", 32'(bus3.e_valid), 32'd1);
        check("post reset issue e_class", 32'(bus3.e_class), 32'(CLS_ALU_R));
        check("post reset issue e_dst", 32'(bus3.e_dst), 32'd9);
        check("post reset issue e_rs", 32'(bus3.e_rs), 32'd8);
        check("post reset issue e_rt", 32'(bus3.e_rt), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_pipe.md
INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

Interface
REQ-001 Parameter STAGES, default 3, meaning number of in-flight downstream stages (E, M, W) tracked by the scoreboard; legal range 2..4.
REQ-002 Parameter TNEW_W, default 2, meaning width of the Tnew field.
REQ-003 Parameter MDU_STALL, default 1, meaning that when 1, MDU-class instructions stall while mdu_busy is high.
REQ-004 Ports: clk  in  1  clock; reset  in  1  synchronous active-high reset (one clock domain; polarity and synchronicity fixed).
REQ-005 instr  in  32  instruction word held in the D stage.
REQ-006 d_valid  in  1  instr is a real instruction; when 0 it is treated as a bubble.
REQ-007 mdu_busy  in  1  multiply/divide unit is busy.
REQ-008 flush  in  1  exception or eret flush request.
REQ-009 stall_out  out  1  hold the F/D registers this cycle.
REQ-010 e_valid  out  1  the E-stage entry is valid.
REQ-011 e_class  out  CLASS_W  instruction class enum for the E stage.
REQ-012 e_rs, e_rt, e_dst  out  5 each  E-stage source and destination register numbers.
REQ-013 e_tnew  out  TNEW_W  remaining Tnew of the E-stage entry.
REQ-014 e_ri  out  1  reserved-instruction exception; e_sys  out  1  syscall.

Function
REQ-015 Decode SHALL recognise: add, addi, sub, and, andi, or, ori, slt, sltu, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, lw, lh, lb, sw, sh, sb, beq, bne, lui, jal, jr, syscall, eret, mfc0, mtc0.
REQ-016 Any other encoding SHALL produce class NOP, dst 0, and ri=1; the all-zero word SHALL be NOP with ri=0.
REQ-017 Destination mapping: R-type ALU ops, mfhi and mflo SHALL use rd; I-type ALU ops, loads, lui and mfc0 SHALL use rt; jal SHALL use 31; all others SHALL use 0.
REQ-018 Tuse(rs) SHALL be 0 for beq, bne and jr, and 1 for all other instructions that read rs.
REQ-019 Tuse(rt) SHALL be 0 for beq and bne, 2 for sw, sh, sb and mtc0, and 1 for R-type ALU and MDU ops.
REQ-020 Tnew at E entry SHALL be 1 for ALU ops, lui, mfhi and mflo; 2 for loads and mfc0; 0 for jal and all others.
REQ-021 The scoreboard SHALL hold STAGES entries {valid, dst, tnew}; on each non-flush edge entry i+1 SHALL take entry i, with tnew decremented and saturating at 0.
REQ-022 Entry 0 SHALL load the decoded instruction, or a bubble (valid=0, dst=0) when stalling or when d_valid=0.
REQ-023 stall_out SHALL assert combinationally when a non-zero source register with Tuse t matches any valid entry's dst with tnew > t.
REQ-024 With MDU_STALL=1, stall_out SHALL also assert when the D instruction is an MDU-class op (mult, div, mf/mt hi/lo) and either mdu_busy=1 or entry 0 holds an MDU start op (mult, multu, div, divu).
REQ-025 Register 0 SHALL never cause a match.
REQ-026 flush SHALL clear all entries to valid=0 at the next edge and SHALL override stall; stall_out SHALL be 0 during a flush cycle.
REQ-027 E outputs SHALL be registered from entry 0, giving one cycle of latency from D to E.
REQ-028 e_ri and e_sys SHALL be forced to 0 when e_valid=0.

Reset
REQ-029 On reset, every entry SHALL become valid=0, dst=0 and tnew=0; e_valid, e_ri and e_sys SHALL be 0; e_class SHALL be NOP; and stall_out SHALL evaluate to 0.
REQ-030 Reset asserted mid-stall SHALL take effect at the same edge, and the next cycle SHALL re-evaluate the stall from an empty scoreboard.

Structure
REQ-031 Package cpu_defs_pkg SHALL hold the opcode, funct and rs-field constants, the class enum and CLASS_W, and the Tuse/Tnew constants.
REQ-032 Combinational sub-module instr_class_decode SHALL map instr to {class, rs, rt, dst, tuse_rs, tuse_rt, tnew, ri, sys}.
REQ-033 The top level SHALL contain only the scoreboard, the stall logic and the E register.

Verification
REQ-034 Scenario: lw $8,0($0) then addu-style add $9,$8,$8 -> stall_out=1 for 1 cycle, the E bubble has e_valid=0, then the add issues.
REQ-035 Scenario: lw $8 then beq $8,$0 -> stall_out=1 for 2 cycles; with add $8 followed by beq $8 -> 1 cycle.
REQ-036 Scenario: ori $8 then sw $8,0($9) -> no stall (Tuse rt=2); instruction 0xFC000000 -> e_ri=1, e_dst=0.
REQ-037 Scenario: mult $1,$2 then mflo $3 with MDU_STALL=1 -> stall_out=1 while mdu_busy=1 (5 cycles driven); the stall releases on the first cycle mdu_busy=0.
REQ-038 Scenario: flush asserted during a lw-use stall -> next cycle all entries are invalid, stall_out=0, e_valid=0.
REQ-039 Scenario: STAGES=4 with lw $0 followed by use of $0 -> no stall; reset pulse mid-sequence -> all outputs at their reset values the following cycle.
